reaction_ctrl: RTL
==================

Name: reaction_ctrl

Overview:
Game controller for the reaction timer. It sits directly downstream of the 16-bit LFSR random generator, whose output is clamped to 2000..15000. At start it captures the random value as a delay in milliseconds, counts that delay down, then lights the stimulus LED. It then measures the player's reaction in milliseconds, flagging false starts and timeouts, and tracks the best score.

Parameters:
CLK_PER_MS, 50000, clk cycles per millisecond tick (50 MHz default)
TIME_W, 16, width of delay/reaction/best counters
TIMEOUT_MS, 9999, maximum reaction time before round is abandoned

Ports:
clk  in  1  system clock
areset  in  1  asynchronous reset, active-high
start  in  1  debounced single-cycle start pulse
react  in  1  debounced single-cycle player button pulse
rnd  in  TIME_W  random delay in ms from the random generator
lfsr_hold  out  1  drives the generator's load input; 1 freezes the LFSR
led  out  1  stimulus light
result_ms  out  TIME_W  last measured reaction time
result_valid  out  1  result_ms holds a valid reaction
false_start  out  1  react arrived before led
timeout  out  1  no react within TIMEOUT_MS
best_ms  out  TIME_W  best valid reaction since reset; all-ones = none
state_dbg  out  3  current state encoding

Behaviour:
- Reset (async, immediate in any state): state IDLE, led=0, lfsr_hold=0, result_ms=0, result_valid=0, false_start=0, timeout=0, best_ms=all-ones, prescaler=0, counters=0.
- ms tick: the prescaler counts 0..CLK_PER_MS-1. tick=1 for one cycle when count==CLK_PER_MS-1, then wraps to 0. The prescaler clears on every state transition, so the first tick in a state arrives exactly CLK_PER_MS cycles after entry.
- States: IDLE=0, DELAY=1, ARMED=2, DONE=3, FOUL=4.
- IDLE, DONE, FOUL: start=1 → delay_cnt<=rnd (0 forced to 1), clear result_valid/false_start/timeout, next state DELAY. result_ms and best_ms are retained. react is ignored.
- DELAY: lfsr_hold=1, led=0.
  - react=1 → FOUL, false_start<=1. react has priority over tick in the same cycle.
  - Otherwise, on tick: if delay_cnt==1 → ARMED with react_cnt<=0; else delay_cnt decrements.
  - led therefore rises rnd*CLK_PER_MS cycles after DELAY entry.
  - start is ignored.
- ARMED: led=1, lfsr_hold=1.
  - react=1 → DONE, result_ms<=react_cnt (the pre-increment value if tick coincides), result_valid<=1. If react_cnt<best_ms, best_ms<=react_cnt. A tie leaves best_ms unchanged.
  - Otherwise, on tick: react_cnt increments. If the incremented value==TIMEOUT_MS → DONE, timeout<=1, result_ms<=TIMEOUT_MS, result_valid stays 0, best_ms unchanged.
  - start is ignored.
- DONE and FOUL: led=0, lfsr_hold=0; all flags hold until the next start.
- All outputs are registered except led, lfsr_hold and state_dbg, which decode combinationally from the state register.
- rnd is sampled only in the start cycle; later changes on rnd have no effect.
- Width rules: counters are TIME_W unsigned. TIMEOUT_MS must be < 2^TIME_W-1, so react_cnt never wraps.

Decomposition:
- Package reaction_pkg holds:
  - state encoding constants ST_IDLE..ST_FOUL (3-bit)
  - BEST_NONE (all-ones)
  - default TIME_W
- One sub-module, ms_prescaler (parameter CLK_PER_MS; ports clk, areset, clr, tick), generates the tick.
- The FSM, counters and score registers stay in reaction_ctrl.

Test Plan (CLK_PER_MS=4, TIMEOUT_MS=9999):
1. rnd=2000, start → state DELAY, lfsr_hold=1. led rises exactly 8000 cycles after DELAY entry. react 250 ticks later → result_ms=250, result_valid=1, best_ms=250, state DONE, led=0.
2. rnd=3000, start, react after 100 ms in DELAY → state FOUL, false_start=1, led never asserted, best_ms unchanged at 250, result_ms still 250.
3. start, no react → timeout=1 exactly 9999 ticks after ARMED entry. result_ms=9999, result_valid=0, best_ms unchanged.
4. Rounds with reactions 300 then 120 ms → best_ms 250 after the first and 120 after the second. A 120 ms tie leaves it 120.
5. react coinciding with a tick when react_cnt=5 → result_ms=5, not 6. react coinciding with the final DELAY tick → FOUL.
6. areset asserted mid-ARMED, between clock edges → led=0, state_dbg=0, best_ms=FFFF immediately. start/react pulses during reset are ignored.

Source files
------------

// File: rtl/reaction_pkg.sv
// Shared constants for the reaction timer game controller.
package reaction_pkg;

    localparam int TIME_W_DEFAULT = 16;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_DELAY = 3'd1;
    localparam logic [2:0] ST_ARMED = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_FOUL  = 3'd4;

    // Marker for "no best score yet"; the top rebuilds it at its own width.
    localparam logic [TIME_W_DEFAULT-1:0] BEST_NONE = '1;

endpackage

// File: rtl/ms_prescaler.sv
// Millisecond tick generator: one-cycle tick every CLK_PER_MS clocks, restartable via clr.
module ms_prescaler #(
    parameter int CLK_PER_MS = 50000
) (
    input  logic clk,
    input  logic areset,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_MS - 1);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    assign tick = (count_reg == CNT_LAST);

    always_comb begin
        count_next = count_reg + 1'b1;
        if (clr || tick) begin
            count_next = '0;
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/reaction_ctrl.sv
// Reaction timer game FSM: random delay, stimulus LED, reaction measurement,
// false-start / timeout detection and best-score tracking.
module reaction_ctrl
    import reaction_pkg::*;
#(
    parameter int CLK_PER_MS = 50000,
    parameter int TIME_W     = TIME_W_DEFAULT,
    parameter int TIMEOUT_MS = 9999
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              start,
    input  logic              react,
    input  logic [TIME_W-1:0] rnd,
    output logic              lfsr_hold,
    output logic              led,
    output logic [TIME_W-1:0] result_ms,
    output logic              result_valid,
    output logic              false_start,
    output logic              timeout,
    output logic [TIME_W-1:0] best_ms,
    output logic [2:0]        state_dbg
);

    localparam logic [TIME_W-1:0] BEST_INIT   = {TIME_W{1'b1}};
    localparam logic [TIME_W-1:0] TIMEOUT_VAL = TIME_W'(TIMEOUT_MS);
    localparam logic [TIME_W-1:0] CNT_ONE     = TIME_W'(1);

    logic [2:0]        state_reg, state_next;
    logic [TIME_W-1:0] delay_cnt_reg, delay_cnt_next;
    logic [TIME_W-1:0] react_cnt_reg, react_cnt_next;
    logic [TIME_W-1:0] result_reg, result_next;
    logic [TIME_W-1:0] best_reg, best_next;
    logic              valid_reg, valid_next;
    logic              false_reg, false_next;
    logic              timeout_reg, timeout_next;
    logic [TIME_W-1:0] react_inc;
    logic              tick;
    logic              clr;

    // Restarting the prescaler on every transition aligns ticks to state entry.
    assign clr = (state_next != state_reg);

    ms_prescaler #(
        .CLK_PER_MS(CLK_PER_MS)
    ) u_prescaler (
        .clk   (clk),
        .areset(areset),
        .clr   (clr),
        .tick  (tick)
    );

    always_comb begin
        state_next     = state_reg;
        delay_cnt_next = delay_cnt_reg;
        react_cnt_next = react_cnt_reg;
        result_next    = result_reg;
        best_next      = best_reg;
        valid_next     = valid_reg;
        false_next     = false_reg;
        timeout_next   = timeout_reg;
        react_inc      = react_cnt_reg + 1'b1;

        case (state_reg)
            ST_IDLE, ST_DONE, ST_FOUL: begin
                if (start) begin
                    delay_cnt_next = (rnd == '0) ? CNT_ONE : rnd;
                    valid_next     = 1'b0;
                    false_next     = 1'b0;
                    timeout_next   = 1'b0;
                    state_next     = ST_DELAY;
                end
            end

            ST_DELAY: begin
                if (react) begin
                    false_next = 1'b1;
                    state_next = ST_FOUL;
                end else if (tick) begin
                    if (delay_cnt_reg == CNT_ONE) begin
                        react_cnt_next = '0;
                        state_next     = ST_ARMED;
                    end else begin
                        delay_cnt_next = delay_cnt_reg - 1'b1;
                    end
                end
            end

            ST_ARMED: begin
                if (react) begin
                    // A coinciding tick is dropped: the reported time is the pre-increment count.
                    result_next = react_cnt_reg;
                    valid_next  = 1'b1;
                    if (react_cnt_reg < best_reg) begin
                        best_next = react_cnt_reg;
                    end
                    state_next = ST_DONE;
                end else if (tick) begin
                    react_cnt_next = react_inc;
                    if (react_inc == TIMEOUT_VAL) begin
                        timeout_next = 1'b1;
                        result_next  = TIMEOUT_VAL;
                        state_next   = ST_DONE;
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_reg     <= ST_IDLE;
            delay_cnt_reg <= '0;
            react_cnt_reg <= '0;
            result_reg    <= '0;
            best_reg      <= BEST_INIT;
            valid_reg     <= 1'b0;
            false_reg     <= 1'b0;
            timeout_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            delay_cnt_reg <= delay_cnt_next;
            react_cnt_reg <= react_cnt_next;
            result_reg    <= result_next;
            best_reg      <= best_next;
            valid_reg     <= valid_next;
            false_reg     <= false_next;
            timeout_reg   <= timeout_next;
        end
    end

    assign led          = (state_reg == ST_ARMED);
    assign lfsr_hold    = (state_reg == ST_DELAY) || (state_reg == ST_ARMED);
    assign state_dbg    = state_reg;
    assign result_ms    = result_reg;
    assign result_valid = valid_reg;
    assign false_start  = false_reg;
    assign timeout      = timeout_reg;
    assign best_ms      = best_reg;

endmodule
